// File: rtl/trace_collector.sv
// trace_collector: merges per-tile trace words into a single tagged stream.
// Each tile has a small FIFO; a round-robin arbiter pops one word per cycle
// into a registered output. Overflowing pushes are dropped and counted.
module trace_collector #(
  parameter int unsigned NT    = 4,
  parameter int unsigned Fpay  = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned SRCw  = (NT > 1) ? $clog2(NT) : 1,
  parameter int unsigned CNTw  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NT-1:0]        trigger_in,
  input  logic [NT*Fpay-1:0]   trace_in,
  input  logic                 hold,
  input  logic                 clr_stat,
  output logic                 trigger_out,
  output logic [Fpay-1:0]      trace_out,
  output logic [SRCw-1:0]      trace_src,
  output logic [NT-1:0]        overflow,
  output logic [CNTw-1:0]      drop_cnt
);

  localparam int unsigned PTRw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCCw = PTRw + 1;
  localparam int unsigned SUMw = CNTw + 1;

  logic [Fpay-1:0] mem_q    [NT][DEPTH];
  logic [PTRw-1:0] wr_ptr_q [NT];
  logic [PTRw-1:0] rd_ptr_q [NT];
  logic [OCCw-1:0] occ_q    [NT];

  logic [SRCw-1:0] rr_q, rr_d;
  logic            grant_valid;
  logic [SRCw-1:0] grant_idx;
  logic [NT-1:0]   pop, push, drop;

  logic [NT-1:0]   overflow_q, overflow_d;
  logic [CNTw-1:0] drop_cnt_q, drop_cnt_d;
  logic [SUMw-1:0] drop_pc, drop_sum;

  logic            trigger_out_q;
  logic [Fpay-1:0] trace_out_q;
  logic [SRCw-1:0] trace_src_q;

  // Round-robin scan of registered occupancies starting at rr_q; hold blocks any grant.
  always_comb begin
    int unsigned     idx;
    logic [SRCw-1:0] idx_s;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    idx_s       = '0;
    for (int k = 0; k < NT; k++) begin
      idx   = (32'(rr_q) + unsigned'(k)) % NT;
      idx_s = SRCw'(idx);
      if (!hold && !grant_valid && (occ_q[idx_s] != '0)) begin
        grant_valid = 1'b1;
        grant_idx   = idx_s;
      end
    end
  end

  // Pointer advances past the granted source; frozen when nothing is granted.
  always_comb begin
    rr_d = rr_q;
    if (grant_valid) begin
      rr_d = (grant_idx == SRCw'(NT - 1)) ? '0 : grant_idx + SRCw'(1);
    end
  end

  // Push is allowed into a full FIFO only when the same FIFO is popped this cycle.
  always_comb begin
    pop  = '0;
    push = '0;
    drop = '0;
    for (int i = 0; i < NT; i++) begin
      pop[i]  = grant_valid && (grant_idx == SRCw'(i));
      push[i] = trigger_in[i] && ((occ_q[i] != OCCw'(DEPTH)) || pop[i]);
      drop[i] = trigger_in[i] && !push[i];
    end
  end

  // Drop statistics: popcount add with saturation; same-cycle drops survive a clear.
  always_comb begin
    drop_pc = '0;
    for (int i = 0; i < NT; i++) begin
      drop_pc = drop_pc + SUMw'(drop[i]);
    end
    drop_sum   = (clr_stat ? '0 : {1'b0, drop_cnt_q}) + drop_pc;
    drop_cnt_d = drop_sum[CNTw] ? '1 : drop_sum[CNTw-1:0];
    overflow_d = (clr_stat ? '0 : overflow_q) | drop;
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NT; i++) begin
      if (push[i]) begin
        mem_q[i][wr_ptr_q[i]] <= trace_in[i*Fpay +: Fpay];
      end
    end
  end

  // FIFO pointers and occupancy counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NT; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        occ_q[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < NT; i++) begin
        if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PTRw'(1);
        if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + PTRw'(1);
        case ({push[i], pop[i]})
          2'b10:   occ_q[i] <= occ_q[i] + OCCw'(1);
          2'b01:   occ_q[i] <= occ_q[i] - OCCw'(1);
          default: occ_q[i] <= occ_q[i];
        endcase
      end
    end
  end

  // Arbiter pointer, output register and statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q          <= '0;
      trigger_out_q <= 1'b0;
      trace_out_q   <= '0;
      trace_src_q   <= '0;
      overflow_q    <= '0;
      drop_cnt_q    <= '0;
    end else begin
      rr_q          <= rr_d;
      trigger_out_q <= grant_valid;
      if (grant_valid) begin
        trace_out_q <= mem_q[grant_idx][rd_ptr_q[grant_idx]];
        trace_src_q <= grant_idx;
      end
      overflow_q    <= overflow_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign trigger_out = trigger_out_q;
  assign trace_out   = trace_out_q;
  assign trace_src   = trace_src_q;
  assign overflow    = overflow_q;
  assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_trace_collector.sv
// Bench for trace_collector: directed stimulus pushes expected {src, word}
// entries into a queue; a negedge monitor pops and compares on every output.
module tb_trace_collector;

  localparam int NT   = 4;
  localparam int FPAY = 32;
  localparam int SRCW = 2;
  localparam int CNTW = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              hold = 1'b0;
  logic              clr_stat = 1'b0;
  logic [NT-1:0]     trigger_in = '0;
  logic [NT*FPAY-1:0] trace_in = '0;
  logic              trigger_out;
  logic [FPAY-1:0]   trace_out;
  logic [SRCW-1:0]   trace_src;
  logic [NT-1:0]     overflow;
  logic [CNTW-1:0]   drop_cnt;

  int checks = 0;
  int failures = 0;
  logic [SRCW+FPAY-1:0] exp_q[$];
  logic [SRCW+FPAY-1:0] mon_exp;

  trace_collector #(
    .NT(NT), .Fpay(FPAY), .DEPTH(4), .SRCw(SRCW), .CNTw(CNTW)
  ) dut (
    .clk(clk), .reset(reset), .trigger_in(trigger_in), .trace_in(trace_in),
    .hold(hold), .clr_stat(clr_stat), .trigger_out(trigger_out),
    .trace_out(trace_out), .trace_src(trace_src), .overflow(overflow),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int t, input logic [FPAY-1:0] w);
    trace_in[t*FPAY +: FPAY] = w;
  endtask

  task automatic exp_push(input int src, input logic [FPAY-1:0] w);
    exp_q.push_back({SRCW'(src), w});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Scoreboard monitor: every output word must match the head of the queue.
  always @(negedge clk) begin
    if (trigger_out === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output actual=src%0d/%h required=none", trace_src, trace_out);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({trace_src, trace_out} !== mon_exp) begin
          failures++;
          $display("FAIL output_word actual=src%0d/%h required=src%0d/%h",
                   trace_src, trace_out, mon_exp[SRCW+FPAY-1:FPAY], mon_exp[FPAY-1:0]);
        end
      end
    end
  end

  initial begin
    // Reset state
    do_reset();
    check("rst_trigger_out", 64'(trigger_out), 64'd0);
    check("rst_trace_out", 64'(trace_out), 64'd0);
    check("rst_trace_src", 64'(trace_src), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);

    // Single word from tile 2: two-cycle latency
    trigger_in = 4'b0100;
    set_word(2, 32'hA5A5_A5A5);
    exp_push(2, 32'hA5A5_A5A5);
    tick();
    trigger_in = '0;
    check("t1_no_bypass", 64'(trigger_out), 64'd0);
    tick();
    check("t1_out_valid", 64'(trigger_out), 64'd1);
    check("t1_src", 64'(trace_src), 64'd2);
    tick();
    check("t1_out_clear", 64'(trigger_out), 64'd0);
    check("t1_out_hold", 64'(trace_out), 64'hA5A5_A5A5);

    // All four tiles at once, p = 0
    do_reset();
    trigger_in = 4'b1111;
    for (int i = 0; i < NT; i++) begin
      set_word(i, 32'h10 + 32'(i));
      exp_push(i, 32'h10 + 32'(i));
    end
    tick();
    trigger_in = '0;
    for (int k = 0; k < NT; k++) begin
      tick();
      check("t2_consecutive", 64'(trigger_out), 64'd1);
    end
    tick();
    check("t2_idle_after", 64'(trigger_out), 64'd0);
    check("t2_drop_cnt", 64'(drop_cnt), 64'd0);

    // Tile 3 overflows under hold, then drains
    hold = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      trigger_in = 4'b1000;
      set_word(3, 32'(i));
      tick();
    end
    trigger_in = '0;
    check("t3_hold_no_out", 64'(trigger_out), 64'd0);
    check("t3_overflow", 64'(overflow), 64'h8);
    check("t3_drop_cnt", 64'(drop_cnt), 64'd2);
    for (int i = 1; i <= 4; i++) exp_push(3, 32'(i));
    hold = 1'b0;
    repeat (6) tick();

    // Full FIFO popped and pushed in the same cycle: no drop
    clr_stat = 1'b1;
    tick();
    clr_stat = 1'b0;
    check("t4_clr_overflow", 64'(overflow), 64'd0);
    check("t4_clr_drop_cnt", 64'(drop_cnt), 64'd0);
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      trigger_in = 4'b0001;
      set_word(0, 32'h70 + 32'(i));
      exp_push(0, 32'h70 + 32'(i));
      tick();
    end
    exp_push(0, 32'h77);
    hold = 1'b0;
    trigger_in = 4'b0001;
    set_word(0, 32'h77);
    tick();
    trigger_in = '0;
    check("t4_no_drop", 64'(drop_cnt), 64'd0);
    check("t4_no_overflow", 64'(overflow), 64'd0);
    repeat (7) tick();

    // Clear coincident with a drop: the drop wins
    hold = 1'b1;
    for (int i = 0; i < 9; i++) begin
      trigger_in = 4'b0010;
      set_word(1, 32'h20 + 32'(i));
      tick();
    end
    check("t5_pre_overflow", 64'(overflow), 64'h2);
    check("t5_pre_drop_cnt", 64'(drop_cnt), 64'd5);
    clr_stat = 1'b1;
    set_word(1, 32'h2F);
    tick();
    clr_stat = 1'b0;
    trigger_in = '0;
    check("t5_clr_overflow", 64'(overflow), 64'h2);
    check("t5_clr_drop_cnt", 64'(drop_cnt), 64'd1);
    for (int i = 0; i < 4; i++) exp_push(1, 32'h20 + 32'(i));
    hold = 1'b0;
    repeat (6) tick();

    // Reset discards buffered words and returns p to 0
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      trigger_in = 4'b0100;
      set_word(2, 32'h30 + 32'(i));
      tick();
    end
    trigger_in = '0;
    do_reset();
    hold = 1'b0;
    check("t6_trigger_out", 64'(trigger_out), 64'd0);
    check("t6_drop_cnt", 64'(drop_cnt), 64'd0);
    check("t6_overflow", 64'(overflow), 64'd0);
    repeat (6) tick();
    trigger_in = 4'b1001;
    set_word(0, 32'h40);
    set_word(3, 32'h43);
    exp_push(0, 32'h40);
    exp_push(3, 32'h43);
    tick();
    trigger_in = '0;
    repeat (4) tick();

    // Multi-source drops add their popcount and saturate
    hold = 1'b1;
    trigger_in = 4'b1111;
    repeat (5) tick();
    check("sat_popcount", 64'(drop_cnt), 64'd4);
    check("sat_overflow", 64'(overflow), 64'hF);
    repeat (16383) tick();
    check("sat_ceiling", 64'(drop_cnt), 64'hFFFF);
    trigger_in = '0;
    do_reset();
    check("sat_reset", 64'(drop_cnt), 64'd0);
    hold = 1'b0;
    repeat (6) tick();

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trace_collector.md
Name: trace_collector

Overview:
- Gathers per-tile debug trace words (trigger/trace pairs from each mor1k_tile) into one stream for the MPSoC trace buffer.
- Sits directly upstream of trace_buffer and replaces the combinational OR / priority-mux merge.
- Buffers each tile in a small FIFO and merges round-robin, so simultaneous triggers are not lost.
- Tags every word with its source tile and counts words dropped on overflow.

Parameters:
- NT, 4, number of trace sources (tiles).
- Fpay, 32, trace word width; matches trace_buffer Fpay.
- DEPTH, 4, per-source FIFO depth in words; power of 2, ≥2.
- SRCw, log2(NT) (min 1), width of the source tag.
- CNTw, 16, drop counter width.

Ports:
- clk, input, 1, single clock.
- reset, input, 1, synchronous active-high reset.
- trigger_in, input, NT, per-tile trace valid; bit i belongs to tile i.
- trace_in, input, NT*Fpay, tile i word at [(i+1)*Fpay-1 : i*Fpay].
- hold, input, 1, trace buffer not accepting (e.g. JTAG readout); stalls output.
- clr_stat, input, 1, clears overflow and drop_cnt.
- trigger_out, output, 1, write enable to trace buffer.
- trace_out, output, Fpay, trace word to trace buffer.
- trace_src, output, SRCw, tile index of trace_out.
- overflow, output, NT, sticky per-tile drop flag.
- drop_cnt, output, CNTw, saturating total of dropped words.

Behaviour:
- Reset (synchronous, active-high):
  - All FIFOs empty; RR pointer = 0.
  - trigger_out = 0; trace_out = 0; trace_src = 0.
  - overflow = 0; drop_cnt = 0.
  - Reset mid-operation discards all buffered words; no output in the cycle after reset.
- Push, per source i each cycle: trigger_in[i]=1 →
  - FIFO i not full, or full and popped this cycle: push trace_in slice i.
  - Otherwise drop the word; set overflow[i]; drop_cnt += 1.
- drop_cnt arithmetic:
  - Saturates at 2^CNTw-1.
  - Multiple drops in one cycle add their popcount, saturating.
- Arbitration, when hold=0:
  - Scan non-empty FIFOs starting at RR pointer p, in order p, p+1, …, NT-1, 0, …
  - Grant the first non-empty FIFO g and pop one word.
  - Next p = (g+1) mod NT.
  - No non-empty FIFO: p unchanged.
- Output register:
  - On a grant, trigger_out=1, trace_out=head word, trace_src=g in the next cycle.
  - Otherwise trigger_out=0; trace_out and trace_src hold their last values.
- Timing:
  - Latency: trigger_in sampled at edge t → trigger_out high in cycle after edge t+1 (2 cycles); no bypass path.
  - Throughput: at most one output word per cycle.
- hold=1:
  - No grant; no pop; trigger_out=0 from the next cycle.
  - Pushes continue; p frozen.
- FIFO occupancy:
  - Push and pop on the same FIFO in the same cycle leave occupancy unchanged; legal at full and at count 1.
  - Push into an empty FIFO is not visible to the arbiter until the following cycle.
- Pointers:
  - Read/write pointers wrap modulo DEPTH.
  - Full/empty via occupancy counter of width log2(DEPTH)+1.
- clr_stat=1 clears overflow and drop_cnt.
  - A drop in the same cycle takes precedence: that bit is set and drop_cnt = that cycle's drop count.

Test Plan:
- Reset, then trigger_in=4'b0100, trace_in[95:64]=0xA5A5A5A5 for one cycle at edge 0 → trigger_out=1 only in cycle after edge 1; trace_out=0xA5A5A5A5; trace_src=2.
- All four trigger in one cycle with words 0x10,0x11,0x12,0x13, p=0 → four consecutive output cycles with src 0,1,2,3 and words 0x10..0x13; then trigger_out=0; drop_cnt=0.
- hold=1; tile 3 triggers 6 consecutive cycles with words 1..6 → overflow=4'b1000, drop_cnt=2. Release hold → outputs 1,2,3,4 on consecutive cycles, src=3.
- Tile 0 FIFO full (hold), then release hold while tile 0 pushes 0x77 in the same cycle → no drop; 0x77 appears after the 4 buffered words.
- overflow[1]=1 with drop_cnt=5; assert clr_stat while tile 1 drops one word → overflow=4'b0010, drop_cnt=1.
- Three words buffered, assert reset for one cycle → trigger_out=0 after reset; no stale words ever emitted; drop_cnt=0; p=0.
